fifo_wr_ptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO. It owns the write binary/Gray pointers, produces the RAM write enable and address, and derives full, almost-full and fill level. The read Gray pointer arrives already passed through the two-flop synchronizer into the write clock domain. The block's Gray write pointer feeds the synchronizer instance on the read side.

---
 rtl/fifo_wr_ptr_ctrl.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
//
// Write-side pointer and flag controller for an asynchronous FIFO.
// Owns the binary and Gray write pointers, produces the RAM write strobe and
// address, and derives the full, almost-full and fill-level flags from the
// read Gray pointer, which arrives already synchronized into this clock domain.
//
// Parameters:
//   ADDR_SIZE    - RAM address width; DEPTH = 2**ADDR_SIZE; pointers are
//                  ADDR_SIZE+1 bits wide. ADDR_SIZE must be 2 or more.
//   AFULL_THRESH - free-slot count at or below which almost_full asserts
//                  (1..DEPTH-1).
//
// Ports:
//   clk          in   write-domain clock
//   rst_n        in   asynchronous active-low reset
//   w_en         in   push request from the producer
//   rq2_rptr     in   [ADDR_SIZE:0]   read Gray pointer, synchronized to clk
//   mem_we       out  RAM write strobe (w_en & ~full, combinational)
//   waddr        out  [ADDR_SIZE-1:0] RAM write address (low bits of wbin)
//   wptr         out  [ADDR_SIZE:0]   registered Gray write pointer
//   full         out  registered full flag
//   almost_full  out  registered almost-full flag
//   wlevel       out  [ADDR_SIZE:0]   registered fill level, 0..DEPTH
//   overflow     out  sticky "push attempted while full" flag; present only
//                     when the macro WR_OVERFLOW_FLAG_EN is defined
//
// Optional feature macro: WR_OVERFLOW_FLAG_EN
// -----------------------------------------------------------------------------
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_en,
    input  logic [ADDR_SIZE:0]   rq2_rptr,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wlevel
`ifdef WR_OVERFLOW_FLAG_EN
    ,
    output logic                 overflow
`endif
);

    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = 1 << ADDR_SIZE;

    // The Gray code of (x + DEPTH) equals gray(x) with its two top bits
    // inverted, so XOR-ing the read pointer with this mask gives the Gray
    // value the write pointer holds when exactly DEPTH entries are in flight.
    localparam logic [PW-1:0] FULL_MASK   = {2'b11, {(ADDR_SIZE-1){1'b0}}};
    localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_wlevel;

    // -------------------------------------------------------------------------
    // Combinational next-state
    // -------------------------------------------------------------------------
    logic          w_accept;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin_sync;
    logic [PW-1:0] w_full_gray;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;
    logic          w_almost_full_next;

    // rst_n is folded in so the strobe reads 0 for the whole reset window,
    // even if the producer keeps w_en high.
    assign w_accept = w_en & ~r_full & rst_n;

    assign w_wbin_next  = r_wbin + PW'(w_accept);
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
    // it. Written as independent reductions so there is no ripple feedback
    // through a single vector.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_rbin
            assign w_rbin_sync[gi] = ^rq2_rptr[PW-1:gi];
        end
    endgenerate

    assign w_full_gray = rq2_rptr ^ FULL_MASK;
    assign w_full_next = (w_wgray_next == w_full_gray);

    // Modular subtraction handles pointer wrap: the extra MSB keeps the
    // difference in 0..DEPTH as long as the read pointer never passes wbin.
    assign w_level_next       = w_wbin_next - w_rbin_sync;
    assign w_almost_full_next = (w_level_next >= AFULL_LEVEL);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin        <= '0;
            r_wptr        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wlevel      <= '0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wptr        <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_wlevel      <= w_level_next;
        end
    end

`ifdef WR_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_en && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_we      = w_accept;
    assign waddr       = r_wbin[ADDR_SIZE-1:0];
    assign wptr        = r_wptr;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wlevel      = r_wlevel;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ptr_ctrl
//
// Scoreboard bench for fifo_wr_ptr_ctrl. The driver applies inputs just after
// each rising edge and pushes the expected outputs for that cycle, computed
// from a count-based model: total writes accepted and total reads seen, with
// occupancy = writes - reads. The monitor pops one expectation per cycle on
// the falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ptr_ctrl;

    localparam int AS    = 4;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 1 << AS;
    localparam int THR   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [PW-1:0] rq2_rptr = '0;
    logic          mem_we;
    logic [AS-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wlevel;
`ifdef WR_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    fifo_wr_ptr_ctrl #(
        .ADDR_SIZE    (AS),
        .AFULL_THRESH (THR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .rq2_rptr    (rq2_rptr),
        .mem_we      (mem_we),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel)
`ifdef WR_OVERFLOW_FLAG_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mem_we;
        logic [AS-1:0] waddr;
        logic [PW-1:0] wptr;
        logic          full;
        logic          afull;
        logic [PW-1:0] level;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain counts of writes accepted and reads observed.
    int m_wcnt  = 0;
    int m_rcnt  = 0;
    int m_level = 0;
    bit m_full  = 1'b0;
    bit m_afull = 1'b0;
    bit m_ovf   = 1'b0;

    function automatic logic [PW-1:0] gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock of stimulus. rc is the total read count the read side has
    // made visible; it must never exceed the writes already committed.
    task automatic step(input bit we, input int rc);
        exp_t e;
        @(posedge clk);
        #1;
        w_en     = we;
        rq2_rptr = gray(rc);
        m_rcnt   = rc;
        e.mem_we = we && !m_full;
        e.waddr  = AS'(m_wcnt % DEPTH);
        e.wptr   = gray(m_wcnt);
        e.full   = m_full;
        e.afull  = m_afull;
        e.level  = PW'(m_level);
        e.ovf    = m_ovf;
        sb_q.push_back(e);
        // state after the coming edge
        if (we && m_full) m_ovf = 1'b1;
        if (e.mem_we) m_wcnt++;
        m_level = m_wcnt - rc;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= DEPTH - THR);
    endtask

    // Assert reset between edges with a push pending, expect everything to
    // read 0 within that same cycle, then release.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        w_en     = 1'b1;
        rq2_rptr = '0;
        e = '{default: '0};
        sb_q.push_back(e);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w_en  = 1'b0;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("mem_we",      32'(mem_we),      32'(mon_e.mem_we));
                chk("waddr",       32'(waddr),       32'(mon_e.waddr));
                chk("wptr",        32'(wptr),        32'(mon_e.wptr));
                chk("full",        32'(full),        32'(mon_e.full));
                chk("almost_full", 32'(almost_full), 32'(mon_e.afull));
                chk("wlevel",      32'(wlevel),      32'(mon_e.level));
`ifdef WR_OVERFLOW_FLAG_EN
                chk("overflow",    32'(overflow),    32'(mon_e.ovf));
`endif
                $display("txn t=%0t rst_n=%0b w_en=%0b rq2=%h mem_we=%0b waddr=%0d wptr=%h full=%0b af=%0b lvl=%0d",
                         $time, rst_n, w_en, rq2_rptr, mem_we, waddr, wptr, full, almost_full, wlevel);
            end
        end
    end

    // Driver
    initial begin
        int h1;
        int h2;
        int rc;
        bit we;

        // Fill to full, overrun, release one slot, refill.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        step(1'b0, 1);
        step(1'b1, 1);
        step(1'b0, 1);

        // Almost-full threshold crossing.
        do_reset();
        for (int i = 0; i < DEPTH - THR; i++) step(1'b1, 0);
        step(1'b0, 0);

        // Continuous streaming with the read pointer trailing by two cycles,
        // long enough to wrap the pointers.
        do_reset();
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < 40; i++) begin
            rc = h2;
            h2 = h1;
            h1 = m_wcnt;
            step(1'b1, rc);
        end
        step(1'b0, m_wcnt);
        step(1'b0, m_wcnt);

        // Reset in mid-stream, then confirm the first push lands at 0.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 0);
        do_reset();
        step(1'b1, 0);
        step(1'b0, 0);

        // Randomized traffic; reads lag writes on average so full is reached.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                we = ($urandom_range(0, 99) < 70);
                rc = m_rcnt;
                if ($urandom_range(0, 3) == 0) rc += $urandom_range(1, 3);
                if (rc > m_wcnt) rc = m_wcnt;
                step(we, rc);
            end
        end

        step(1'b0, m_rcnt);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
